// File: rtl/task_10_in.sv
// Packet ingress buffer: collects manager beats into a FIFO, then drains them
// first-word-fall-through to the task core, splitting packets longer than DEPTH.
module task_10_in #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tmanager_valid,
    input  logic [DATA_WIDTH-1:0] i_tmanager_data,
    input  logic                  i_tmanager_last,
    input  logic                  i_core_ready,
    output logic                  o_tmanager_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_input_last,
    output logic                  o_busy,
    output logic                  o_empty,
    output logic [11:0]           o_packet_size_in_bytes
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SIZE_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic                seg_last_q, seg_last_d;
    logic [DATA_WIDTH-1:0] buf_mem [DEPTH];

    logic accept;
    logic pop;
    logic full_on_accept;

    // Write side is open only outside DRAIN, so write and read never coincide.
    always_comb begin
        accept         = i_tmanager_valid && (state_q != DRAIN);
        pop            = (state_q == DRAIN) && (count_q != '0) && i_core_ready;
        full_on_accept = (count_q == CNT_W'(DEPTH - 1));

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        size_d     = size_q;
        seg_last_d = seg_last_q;

        case (state_q)
            IDLE, RECEIVE: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                    size_d   = size_q + SIZE_W'(1);
                    // last wins over full when both end the segment on one beat
                    if (i_tmanager_last || full_on_accept) begin
                        state_d    = DRAIN;
                        seg_last_d = i_tmanager_last;
                    end else begin
                        state_d = RECEIVE;
                    end
                end
            end
            DRAIN: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d    = IDLE;
                        seg_last_d = 1'b0;
                        size_d     = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state; reset dominates every other input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            size_q     <= '0;
            seg_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            size_q     <= size_d;
            seg_last_q <= seg_last_d;
        end
    end

    // Storage carries no reset; contents are invalidated through the count.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept) begin
            buf_mem[wr_ptr_q] <= i_tmanager_data;
        end
    end

    assign o_tmanager_ready       = (state_q != DRAIN);
    assign o_data                 = buf_mem[rd_ptr_q];
    assign o_data_valid           = (state_q == DRAIN) && (count_q != '0);
    assign o_input_last           = o_data_valid && (count_q == CNT_W'(1)) && seg_last_q;
    assign o_busy                 = (state_q != IDLE);
    assign o_empty                = (count_q == '0);
    assign o_packet_size_in_bytes = size_q;

endmodule

// File: tb/tb_task_10_in.sv
// Scoreboard bench for task_10_in: accepted beats are queued with their
// expected last marker and checked as the core pops them.
module tb_task_10_in;

    logic        clk;
    logic        rst;
    logic        tm_valid;
    logic [7:0]  tm_data;
    logic        tm_last;
    logic        core_ready;
    logic        tm_ready;
    logic [7:0]  data;
    logic        data_valid;
    logic        input_last;
    logic        busy;
    logic        empty;
    logic [11:0] size;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    logic [8:0] sb [$];

    task_10_in #(.DATA_WIDTH(8), .DEPTH(32)) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_tmanager_valid       (tm_valid),
        .i_tmanager_data        (tm_data),
        .i_tmanager_last        (tm_last),
        .i_core_ready           (core_ready),
        .o_tmanager_ready       (tm_ready),
        .o_data                 (data),
        .o_data_valid           (data_valid),
        .o_input_last           (input_last),
        .o_busy                 (busy),
        .o_empty                (empty),
        .o_packet_size_in_bytes (size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Pop-side scoreboard: a pop happens on the next edge when valid && ready.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (!rst && data_valid && core_ready) begin
            n_checks++;
            n_pops++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL pop_unexpected: got data=%h last=%b, required no word", data, input_last);
            end else begin
                exp = sb.pop_front();
                if ({data, input_last} !== exp) begin
                    n_errors++;
                    $display("FAIL pop_word: got data=%h last=%b, required data=%h last=%b",
                             data, input_last, exp[8:1], exp[0]);
                end
            end
        end
    end

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int budget = 200;
        tm_valid = 1'b1;
        tm_data  = d;
        tm_last  = l;
        @(negedge clk);
        while (!tm_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_errors++;
            $display("FAIL send_timeout: ready stayed %b, required 1", tm_ready);
        end
        @(posedge clk);
        #1;
        sb.push_back({d, l});
    endtask

    task automatic wait_idle();
        int budget = 200;
        @(negedge clk);
        while (busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_errors++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks += 6;
        if (tm_ready !== 1'b1)   begin n_errors++; $display("FAIL reset_ready: got %b, required 1", tm_ready); end
        if (data_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, required 0", data_valid); end
        if (input_last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b, required 0", input_last); end
        if (busy !== 1'b0)       begin n_errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (empty !== 1'b1)      begin n_errors++; $display("FAIL reset_empty: got %b, required 1", empty); end
        if (size !== 12'd0)      begin n_errors++; $display("FAIL reset_size: got %0d, required 0", size); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_four_beat();
        core_ready = 1'b1;
        send_beat(8'h11, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL four_receive: busy=%b valid=%b, required busy=1 valid=0", busy, data_valid);
        end
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b1);
        tm_valid = 1'b0;
        n_checks += 3;
        if (data_valid !== 1'b1) begin n_errors++; $display("FAIL four_latency: valid=%b, required 1", data_valid); end
        if (data !== 8'h11)      begin n_errors++; $display("FAIL four_head: data=%h, required 11", data); end
        if (tm_ready !== 1'b0)   begin n_errors++; $display("FAIL four_ready: ready=%b, required 0", tm_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (data_valid !== 1'b1 || size !== 12'd4) begin
                n_errors++;
                $display("FAIL four_drain[%0d]: valid=%b size=%0d, required valid=1 size=4", i, data_valid, size);
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || size !== 12'd0 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL four_idle: busy=%b size=%0d empty=%b, required 0 0 1", busy, size, empty);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_long_packet();
        core_ready = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            send_beat(8'(i + 8'h80), (i == 40) ? 1'b1 : 1'b0);
            if (i == 32) begin
                n_checks++;
                if (tm_ready !== 1'b0 || size !== 12'd32 || input_last !== 1'b0) begin
                    n_errors++;
                    $display("FAIL long_full: ready=%b size=%0d last=%b, required 0 32 0", tm_ready, size, input_last);
                end
            end
            if (i == 33) begin
                n_checks++;
                if (size !== 12'd1) begin
                    n_errors++;
                    $display("FAIL long_segment2_start: size=%0d, required 1", size);
                end
            end
        end
        tm_valid = 1'b0;
        n_checks++;
        if (size !== 12'd8 || data !== 8'hA1) begin
            n_errors++;
            $display("FAIL long_segment2: size=%0d head=%h, required 8 a1", size, data);
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        core_ready = 1'b0;
        send_beat(8'hA1, 1'b0);
        send_beat(8'hA2, 1'b0);
        send_beat(8'hA3, 1'b0);
        send_beat(8'hA4, 1'b1);
        tm_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            core_ready = pat[i];
            @(negedge clk);
            if (i >= 1) begin
                n_checks++;
                if (data !== 8'hA2 || data_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_hold[%0d]: data=%h valid=%b, required a2 1", i, data, data_valid);
                end
            end
            @(posedge clk);
            #1;
        end
        core_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_single_beat();
        core_ready = 1'b1;
        send_beat(8'h5A, 1'b1);
        tm_valid = 1'b0;
        n_checks++;
        if (data_valid !== 1'b1 || input_last !== 1'b1 || data !== 8'h5A || size !== 12'd1) begin
            n_errors++;
            $display("FAIL single_drain: valid=%b last=%b data=%h size=%0d, required 1 1 5a 1",
                     data_valid, input_last, data, size);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || empty !== 1'b1 || input_last !== 1'b0) begin
            n_errors++;
            $display("FAIL single_idle: busy=%b empty=%b last=%b, required 0 1 0", busy, empty, input_last);
        end
    endtask

    task automatic test_reset_mid_drain();
        core_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(8'(8'hC0 + i), (i == 4) ? 1'b1 : 1'b0);
        tm_valid = 1'b0;
        core_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        core_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (data !== 8'hC2 || data_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_drain_head: data=%h valid=%b, required c2 1", data, data_valid);
        end
        rst = 1'b1;
        tm_valid = 1'b1;
        tm_data  = 8'hEE;
        core_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tm_valid = 1'b0;
        core_ready = 1'b0;
        sb.delete();
        n_checks++;
        if (empty !== 1'b1 || data_valid !== 1'b0 || tm_ready !== 1'b1 || size !== 12'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_drain_state: empty=%b valid=%b ready=%b size=%0d busy=%b, required 1 0 1 0 0",
                     empty, data_valid, tm_ready, size, busy);
        end
    endtask

    task automatic test_valid_in_drain();
        core_ready = 1'b1;
        send_beat(8'h71, 1'b0);
        send_beat(8'h72, 1'b0);
        send_beat(8'h73, 1'b1);
        tm_data = 8'h99;
        tm_last = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tm_ready !== 1'b0 || size !== 12'd3) begin
            n_errors++;
            $display("FAIL drain_stall: ready=%b size=%0d, required 0 3", tm_ready, size);
        end
        @(negedge clk);
        n_checks++;
        if (size !== 12'd3 || data !== 8'h72) begin
            n_errors++;
            $display("FAIL drain_stall_hold: size=%0d head=%h, required 3 72", size, data);
        end
        send_beat(8'h99, 1'b1);
        tm_valid = 1'b0;
        n_checks++;
        if (size !== 12'd1 || busy !== 1'b1 || data !== 8'h99 || input_last !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_then_accept: size=%0d busy=%b data=%h last=%b, required 1 1 99 1",
                     size, busy, data, input_last);
        end
        wait_idle();
    endtask

    initial begin
        rst        = 1'b1;
        tm_valid   = 1'b0;
        tm_data    = 8'h00;
        tm_last    = 1'b0;
        core_ready = 1'b0;
        test_reset();
        test_four_beat();
        test_long_packet();
        test_backpressure();
        test_single_beat();
        test_reset_mid_drain();
        test_valid_in_drain();
        repeat (2) @(posedge clk);
        n_checks++;
        if (sb.size() != 0 || n_pops != 4 + 40 + 4 + 1 + 2 + 4) begin
            n_errors++;
            $display("FAIL scoreboard_final: pending=%0d pops=%0d, required 0 55", sb.size(), n_pops);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
